// File: rtl/timer_avalon_master_if.sv
// Avalon-MM link between the timer master and a 16-bit timer slave.
// The slave has no waitrequest; read data is valid one cycle after the
// address is presented, and irq is a level interrupt.
interface timer_avalon_master_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/timer_avalon_master.sv
// Timer Avalon-MM master: programs a 16-bit timer slave with a 32-bit
// period, arms it, services each timeout interrupt and counts them.
//
// Optional feature: define TIMER_AVALON_MASTER_SNAPSHOT_EN to latch and
// read back the slave's 32-bit counter snapshot on every serviced timeout
// (adds WR_SNAP, RD_SL, RD_SH). Without it, CLR_ST goes straight to CAP
// and snapshot is constant zero.
module timer_avalon_master #(
    parameter int TICK_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [31:0]           period,
    timer_avalon_master_if.master av,
    output logic                  busy,
    output logic                  armed,
    output logic                  tick,
    output logic [TICK_W-1:0]     tick_count,
    output logic [31:0]           snapshot
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] WR_PL    = 4'd1;
    localparam logic [3:0] WR_PH    = 4'd2;
    localparam logic [3:0] WR_CTL   = 4'd3;
    localparam logic [3:0] WAIT_IRQ = 4'd4;
    localparam logic [3:0] CLR_ST   = 4'd5;
    localparam logic [3:0] CAP      = 4'd6;
    localparam logic [3:0] WR_STOP  = 4'd7;
`ifdef TIMER_AVALON_MASTER_SNAPSHOT_EN
    localparam logic [3:0] WR_SNAP  = 4'd8;
    localparam logic [3:0] RD_SL    = 4'd9;
    localparam logic [3:0] RD_SH    = 4'd10;
`endif

    // Slave register map
    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_PERL   = 3'd2;
    localparam logic [2:0] ADDR_PERH   = 3'd3;
    localparam logic [2:0] ADDR_SNAPL  = 3'd4;
    localparam logic [2:0] ADDR_SNAPH  = 3'd5;

    logic [3:0]        state_q;
    logic [3:0]        state_d;
    logic [31:0]       period_q;
    logic [TICK_W-1:0] tick_count_q;
    // Set once irq has been seen low (or the timer was freshly armed);
    // a new service is only started while this is set, so a level irq
    // that has not yet dropped after CAP cannot trigger a second service.
    logic              irq_rearm_q;

    // Next-state decode; start/stop are only looked at in their own state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = WR_PL;
            WR_PL:    state_d = WR_PH;
            WR_PH:    state_d = WR_CTL;
            WR_CTL:   state_d = WAIT_IRQ;
            WAIT_IRQ: begin
                if (stop)
                    state_d = WR_STOP;
                else if (av.irq && irq_rearm_q)
                    state_d = CLR_ST;
            end
`ifdef TIMER_AVALON_MASTER_SNAPSHOT_EN
            CLR_ST:   state_d = WR_SNAP;
            WR_SNAP:  state_d = RD_SL;
            RD_SL:    state_d = RD_SH;
            RD_SH:    state_d = CAP;
`else
            CLR_ST:   state_d = CAP;
`endif
            CAP:      state_d = WAIT_IRQ;
            WR_STOP:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State register; reset aborts any access on the same edge
    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Period is captured only when start is accepted
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start)
            period_q <= period;
    end

    // Timeout counter: cleared on arming, bumped once per service (wraps)
    always_ff @(posedge clk) begin
        if (!reset_n)
            tick_count_q <= '0;
        else if (state_q == WR_CTL)
            tick_count_q <= '0;
        else if (state_q == CAP)
            tick_count_q <= tick_count_q + 1'b1;
    end

    // Interrupt re-arm tracking: CAP consumes it, a low irq restores it
    always_ff @(posedge clk) begin
        if (!reset_n)
            irq_rearm_q <= 1'b0;
        else if (state_q == WR_CTL)
            irq_rearm_q <= 1'b1;
        else if (state_q == CAP)
            irq_rearm_q <= 1'b0;
        else if (!av.irq)
            irq_rearm_q <= 1'b1;
    end

    // Bus drive: one single-cycle access per bus state, idle values elsewhere
    always_comb begin
        av.chipselect = 1'b0;
        av.write_n    = 1'b1;
        av.address    = 3'd0;
        av.writedata  = 16'h0000;
        case (state_q)
            WR_PL: begin
                av.chipselect = 1'b1;
                av.write_n    = 1'b0;
                av.address    = ADDR_PERL;
                av.writedata  = period_q[15:0];
            end
            WR_PH: begin
                av.chipselect = 1'b1;
                av.write_n    = 1'b0;
                av.address    = ADDR_PERH;
                av.writedata  = period_q[31:16];
            end
            WR_CTL: begin
                av.chipselect = 1'b1;
                av.write_n    = 1'b0;
                av.address    = ADDR_CTRL;
                av.writedata  = 16'h0001;
            end
            CLR_ST: begin
                av.chipselect = 1'b1;
                av.write_n    = 1'b0;
                av.address    = ADDR_STATUS;
                av.writedata  = 16'h0000;
            end
`ifdef TIMER_AVALON_MASTER_SNAPSHOT_EN
            WR_SNAP: begin
                av.chipselect = 1'b1;
                av.write_n    = 1'b0;
                av.address    = ADDR_SNAPL;
                av.writedata  = 16'h0000;
            end
            RD_SL: begin
                av.chipselect = 1'b1;
                av.address    = ADDR_SNAPL;
            end
            RD_SH: begin
                av.chipselect = 1'b1;
                av.address    = ADDR_SNAPH;
            end
`endif
            WR_STOP: begin
                av.chipselect = 1'b1;
                av.write_n    = 1'b0;
                av.address    = ADDR_CTRL;
                av.writedata  = 16'h0000;
            end
            default: begin
                av.chipselect = 1'b0;
            end
        endcase
    end

    // Status flags derived directly from the state
    always_comb begin
        armed = 1'b0;
        case (state_q)
            WAIT_IRQ, CLR_ST, CAP: armed = 1'b1;
`ifdef TIMER_AVALON_MASTER_SNAPSHOT_EN
            WR_SNAP, RD_SL, RD_SH: armed = 1'b1;
`endif
            default:               armed = 1'b0;
        endcase
    end

    assign busy       = (state_q != IDLE) && (state_q != WAIT_IRQ);
    assign tick       = (state_q == CAP);
    assign tick_count = tick_count_q;

`ifdef TIMER_AVALON_MASTER_SNAPSHOT_EN
    logic [31:0] snapshot_q;

    // Read data arrives one cycle after its address: low half lands while
    // RD_SH is presenting the high address, high half lands in CAP
    always_ff @(posedge clk) begin
        if (!reset_n)
            snapshot_q <= '0;
        else if (state_q == RD_SH)
            snapshot_q[15:0] <= av.readdata;
        else if (state_q == CAP)
            snapshot_q[31:16] <= av.readdata;
    end

    assign snapshot = snapshot_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^av.readdata;
    assign snapshot        = '0;
`endif

endmodule

// File: doc/timer_avalon_master.md
TIMER_AVALON_MASTER -- requirements
Module: timer_avalon_master

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port start, input, 1, one-cycle request to program and arm the timer; honoured only in IDLE.
REQ-004 SHALL have port stop, input, 1, one-cycle request to disable the timer interrupt; honoured only in WAIT_IRQ.
REQ-005 SHALL have port period, input, 32, period value, sampled on the cycle start is accepted.
REQ-006 SHALL have ports address (output, 3), chipselect (output, 1), write_n (output, 1) and writedata (output, 16) as the Avalon-MM initiator to the 16-bit timer slave.
REQ-007 SHALL have ports readdata (input, 16; slave data, valid one cycle after address is presented) and irq (input, 1; level interrupt from the slave).
REQ-008 SHALL have ports busy (output, 1; high in every state except IDLE and WAIT_IRQ), armed (output, 1; high in WAIT_IRQ and the service states), tick (output, 1; one-cycle pulse per serviced timeout), tick_count (output, 16; serviced-timeout counter) and snapshot (output, 32; last captured counter value).

Function
REQ-009 SHALL implement states IDLE, WR_PL, WR_PH, WR_CTL, WAIT_IRQ, CLR_ST, WR_SNAP, RD_SL, RD_SH, CAP, WR_STOP.
REQ-010 SHALL issue exactly one slave access per bus state, each lasting one cycle (the slave has no waitrequest).
REQ-011 SHALL drive chipselect=0, write_n=1, address=0, writedata=0 in IDLE, WAIT_IRQ and CAP.
REQ-012 IDLE: on start=1, SHALL latch period and go to WR_PL.
REQ-013 WR_PL: SHALL write address 2 with period[15:0], then go to WR_PH.
REQ-014 WR_PH: SHALL write address 3 with period[31:16], then go to WR_CTL.
REQ-015 WR_CTL: SHALL write address 1 with 16'h0001, clear tick_count to 0, then go to WAIT_IRQ.
REQ-016 WAIT_IRQ: stop=1 SHALL take priority over irq and go to WR_STOP; otherwise irq=1 SHALL go to CLR_ST.
REQ-017 CLR_ST: SHALL write address 0 with 16'h0000 (clears the slave timeout flag), then go to WR_SNAP (macro defined) or CAP (macro undefined).
REQ-018 WR_SNAP: SHALL write address 4 with 16'h0000 to latch the slave snapshot, then go to RD_SL.
REQ-019 RD_SL: SHALL present a read (chipselect=1, write_n=1) at address 4, then go to RD_SH.
REQ-020 RD_SH: SHALL present a read at address 5, capture readdata into snapshot[15:0] on this cycle's edge, then go to CAP.
REQ-021 CAP: SHALL capture readdata into snapshot[31:16] (macro defined only), increment tick_count modulo 2^16 (16'hFFFF wraps to 0), pulse tick for exactly this cycle, then go to WAIT_IRQ.
REQ-022 The irq level still high when CAP returns to WAIT_IRQ SHALL NOT cause a second service; WAIT_IRQ SHALL ignore irq on its first cycle after CAP (status clear takes effect one cycle later).
REQ-023 WR_STOP: SHALL write address 1 with 16'h0000, then go to IDLE.
REQ-024 start outside IDLE and stop outside WAIT_IRQ SHALL be ignored and not queued.
REQ-025 period=0 SHALL be written as-is, with no special casing.

Reset
REQ-026 With reset_n=0 at a clock edge, SHALL enter IDLE with chipselect=0, write_n=1, address=0, writedata=0, busy=0, armed=0, tick=0, tick_count=0, snapshot=0.
REQ-027 Reset asserted mid-sequence SHALL abort any access the same edge; no partial write SHALL be completed afterwards.

Configuration
REQ-028 Macro TIMER_AVALON_MASTER_SNAPSHOT_EN defined: SHALL include WR_SNAP, RD_SL and RD_SH; snapshot updated per REQ-020 and REQ-021.
REQ-029 Macro undefined: SHALL omit those states and paths; CLR_ST goes directly to CAP; snapshot constant 0; service latency irq-to-tick 2 cycles instead of 5.

Verification
REQ-030 start with period=32'h0001_86A0 -> writes addr2=16'h86A0, addr3=16'h0001, addr1=16'h0001 on three consecutive cycles; armed=1 next cycle.
REQ-031 irq rises while slave snapshot is 32'h0000_1234 (macro defined) -> write addr0, write addr4, read addr4, read addr5; tick pulses once; snapshot=32'h0000_1234; tick_count=1.
REQ-032 irq held high for 20 cycles after a single service -> tick_count stays 1; no second CLR_ST.
REQ-033 stop and irq asserted on the same WAIT_IRQ cycle -> write addr1=16'h0000, IDLE; tick not pulsed.
REQ-034 tick_count preset to 16'hFFFF through 65535 services, then one more irq -> tick_count=0, tick=1.
REQ-035 reset_n=0 during RD_SL -> next cycle IDLE, chipselect=0, all outputs at reset values.
